// File: rtl/gpu_pkg.sv
// Shared GPU core definitions: sequencer state encoding and default widths.
package gpu_pkg;

  localparam int DEF_THREADS = 4;
  localparam int DEF_PAB     = 8;

  typedef enum logic [3:0] {
    CS_IDLE    = 4'd0,
    CS_FETCH   = 4'd1,
    CS_DECODE  = 4'd2,
    CS_ISSUE   = 4'd3,
    CS_REQUEST = 4'd4,
    CS_WAIT    = 4'd5,
    CS_EXECUTE = 4'd6,
    CS_UPDATE  = 4'd7,
    CS_DONE    = 4'd8
  } core_state_t;

endpackage

// File: rtl/thread_pc_select.sv
// Picks the block PC from the lowest-index enabled thread and flags any
// enabled thread that disagrees with it.
module thread_pc_select #(
  parameter int THREADS  = 4,
  parameter int PAB      = 8,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic [THREADS-1:0]     thread_enable,
  input  logic [THREADS*PAB-1:0] next_pc,
  output logic [PAB-1:0]         sel_pc,
  output logic                   mismatch
);

  // Descending scan so the lowest enabled index is the last (winning) write.
  always_comb begin
    sel_pc = '0;
    for (int i = THREADS - 1; i >= 0; i--)
      if (thread_enable[i]) sel_pc = next_pc[i*PAB +: PAB];
  end

  generate
    if (CHECK_EN) begin : g_chk
      always_comb begin
        mismatch = 1'b0;
        for (int i = 0; i < THREADS; i++)
          if (thread_enable[i] && (next_pc[i*PAB +: PAB] != sel_pc)) mismatch = 1'b1;
      end
    end else begin : g_nochk
      assign mismatch = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/core_sequencer.sv
// Per-core control FSM stepping FETCH..UPDATE and owning the shared block PC.
// Optional divergence flag built only with CORE_SEQ_DIVERGENCE_CHECK_EN defined.
module core_sequencer
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = DEF_THREADS,
  parameter int PROGRAM_ADDR_BITS = DEF_PAB
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       start,
  input  logic [THREADS_PER_BLOCK-1:0]               thread_enable,
  input  logic                                       instruction_valid,
  input  logic                                       decoded_mem_read_enable,
  input  logic                                       decoded_mem_write_enable,
  input  logic                                       decoded_ret,
  input  logic [THREADS_PER_BLOCK-1:0]               lsu_busy,
  input  logic [THREADS_PER_BLOCK*PROGRAM_ADDR_BITS-1:0] next_pc,
  output logic [3:0]                                 core_state,
  output logic [PROGRAM_ADDR_BITS-1:0]               current_pc,
  output logic                                       fetch_req,
  output logic                                       done,
  output logic                                       diverged
);

`ifdef CORE_SEQ_DIVERGENCE_CHECK_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  core_state_t                  state_q;
  logic [PROGRAM_ADDR_BITS-1:0] pc_q;
  logic                         done_q;
  logic [PROGRAM_ADDR_BITS-1:0] sel_pc;
  logic                         sel_mismatch;
  logic                         mem_op;
  logic                         lsu_pending;

  thread_pc_select #(
    .THREADS  (THREADS_PER_BLOCK),
    .PAB      (PROGRAM_ADDR_BITS),
    .CHECK_EN (DIV_EN)
  ) u_pc_sel (
    .thread_enable (thread_enable),
    .next_pc       (next_pc),
    .sel_pc        (sel_pc),
    .mismatch      (sel_mismatch)
  );

  assign mem_op      = decoded_mem_read_enable | decoded_mem_write_enable;
  assign lsu_pending = |(lsu_busy & thread_enable);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CS_IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        CS_IDLE: if (start) begin
          if (|thread_enable) begin
            state_q <= CS_FETCH;
            pc_q    <= '0;
          end else begin
            state_q <= CS_DONE;
            done_q  <= 1'b1;
          end
        end
        CS_FETCH:   if (instruction_valid) state_q <= CS_DECODE;
        CS_DECODE:  state_q <= CS_ISSUE;
        CS_ISSUE:   state_q <= CS_REQUEST;
        CS_REQUEST: state_q <= CS_WAIT;
        CS_WAIT:    if (!mem_op || !lsu_pending) state_q <= CS_EXECUTE;
        CS_EXECUTE: state_q <= CS_UPDATE;
        CS_UPDATE: begin
          if (decoded_ret) begin
            state_q <= CS_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= CS_FETCH;
            pc_q    <= sel_pc;
          end
        end
        CS_DONE:    done_q <= 1'b1;
        default:    state_q <= CS_IDLE;
      endcase
    end
  end

`ifdef CORE_SEQ_DIVERGENCE_CHECK_EN
  logic div_q;
  always_ff @(posedge clk) begin
    if (reset) div_q <= 1'b0;
    else if (state_q == CS_UPDATE && !decoded_ret && sel_mismatch) div_q <= 1'b1;
  end
  assign diverged = div_q;
`else
  logic unused_mismatch;
  assign unused_mismatch = sel_mismatch;
  assign diverged        = 1'b0;
`endif

  assign core_state = state_q;
  assign current_pc = pc_q;
  assign fetch_req  = (state_q == CS_FETCH);
  assign done       = done_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: stimulus queues per-cycle expectations,
// a monitor pops and compares them after each clock edge.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  thread_enable;
  logic        instruction_valid;
  logic        decoded_mem_read_enable;
  logic        decoded_mem_write_enable;
  logic        decoded_ret;
  logic [3:0]  lsu_busy;
  logic [31:0] next_pc;
  logic [3:0]  core_state;
  logic [7:0]  current_pc;
  logic        fetch_req;
  logic        done;
  logic        diverged;

`ifdef CORE_SEQ_DIVERGENCE_CHECK_EN
  localparam bit DIV_EXP = 1'b1;
`else
  localparam bit DIV_EXP = 1'b0;
`endif

  typedef struct {
    string      nm;
    logic [3:0] st;
    logic [7:0] pc;
    logic       dn;
    logic       dv;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  core_sequencer #(.THREADS_PER_BLOCK(4), .PROGRAM_ADDR_BITS(8)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .start                    (start),
    .thread_enable            (thread_enable),
    .instruction_valid        (instruction_valid),
    .decoded_mem_read_enable  (decoded_mem_read_enable),
    .decoded_mem_write_enable (decoded_mem_write_enable),
    .decoded_ret              (decoded_ret),
    .lsu_busy                 (lsu_busy),
    .next_pc                  (next_pc),
    .core_state               (core_state),
    .current_pc               (current_pc),
    .fetch_req                (fetch_req),
    .done                     (done),
    .diverged                 (diverged)
  );

  always #5 clk = ~clk;

  // Monitor: one expectation covers the outputs right after one rising edge.
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if (core_state !== e.st || current_pc !== e.pc || done !== e.dn ||
          diverged !== e.dv || fetch_req !== (e.st == 4'd1)) begin
        miscompares++;
        $display("FAIL %s: got state=%0d pc=%h done=%b div=%b fetch_req=%b, expected state=%0d pc=%h done=%b div=%b fetch_req=%b",
                 e.nm, core_state, current_pc, done, diverged, fetch_req,
                 e.st, e.pc, e.dn, e.dv, (e.st == 4'd1));
      end
    end
  end

  // Queue the expected outputs after the coming edge, then advance one cycle.
  task automatic tick(input string nm, input logic [3:0] st, input logic [7:0] pc,
                      input logic dn, input logic dv);
    exp_t e;
    e.nm = nm; e.st = st; e.pc = pc; e.dn = dn; e.dv = dv;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; thread_enable = 4'b1111; instruction_valid = 1'b1;
    decoded_mem_read_enable = 1'b0; decoded_mem_write_enable = 1'b0; decoded_ret = 1'b0;
    lsu_busy = 4'b0000; next_pc = {4{8'h01}};
    @(negedge clk);

    // 1: straight-line instruction, 7 cycles FETCH..UPDATE
    tick("reset", 4'd0, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    tick("idle_hold", 4'd0, 8'h00, 1'b0, 1'b0);
    start = 1'b1;
    tick("t1_fetch", 4'd1, 8'h00, 1'b0, 1'b0);
    start = 1'b0;
    for (int s = 2; s <= 7; s++) tick("t1_pipe", 4'(s), 8'h00, 1'b0, 1'b0);
    tick("t1_next_pc", 4'd1, 8'h01, 1'b0, 1'b0);

    // 2: LDR with busy threads for three WAIT cycles
    decoded_mem_read_enable = 1'b1; next_pc = {4{8'h02}};
    tick("t2_decode", 4'd2, 8'h01, 1'b0, 1'b0);
    tick("t2_issue", 4'd3, 8'h01, 1'b0, 1'b0);
    tick("t2_request", 4'd4, 8'h01, 1'b0, 1'b0);
    lsu_busy = 4'b0101;
    for (int w = 0; w < 4; w++) tick("t2_wait", 4'd5, 8'h01, 1'b0, 1'b0);
    lsu_busy = 4'b0000;
    tick("t2_execute", 4'd6, 8'h01, 1'b0, 1'b0);
    tick("t2_update", 4'd7, 8'h01, 1'b0, 1'b0);
    tick("t2_next_pc", 4'd1, 8'h02, 1'b0, 1'b0);

    // 3: busy only on disabled threads; lowest enabled is thread 2
    thread_enable = 4'b1100; lsu_busy = 4'b0011;
    next_pc = {8'h30, 8'h30, 8'h20, 8'h10};
    for (int s = 2; s <= 7; s++) tick("t3_masked_wait", 4'(s), 8'h02, 1'b0, 1'b0);
    tick("t3_thread2_pc", 4'd1, 8'h30, 1'b0, 1'b0);

    // 4: RET finishes the block; start is ignored in DONE
    thread_enable = 4'b1111; lsu_busy = 4'b0000; decoded_mem_read_enable = 1'b0;
    decoded_ret = 1'b1; next_pc = {4{8'h55}};
    for (int s = 2; s <= 7; s++) tick("t4_pipe", 4'(s), 8'h30, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      start = k[0];
      tick("t4_done_hold", 4'd8, 8'h30, 1'b1, 1'b0);
    end
    start = 1'b0; decoded_ret = 1'b0;

    // 5: reset in the middle of a stalled WAIT
    reset = 1'b1;
    tick("t5_reset_done", 4'd0, 8'h00, 1'b0, 1'b0);
    reset = 1'b0; start = 1'b1; decoded_mem_read_enable = 1'b1;
    lsu_busy = 4'b1111; next_pc = {4{8'h01}};
    tick("t5_fetch", 4'd1, 8'h00, 1'b0, 1'b0);
    start = 1'b0;
    for (int s = 2; s <= 5; s++) tick("t5_pipe", 4'(s), 8'h00, 1'b0, 1'b0);
    tick("t5_wait_stall", 4'd5, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    tick("t5_reset_in_wait", 4'd0, 8'h00, 1'b0, 1'b0);
    reset = 1'b0; decoded_mem_read_enable = 1'b0; lsu_busy = 4'b0000;
    tick("t5_idle", 4'd0, 8'h00, 1'b0, 1'b0);

    // 6: threads disagree on next PC
    start = 1'b1; next_pc = {8'h05, 8'h05, 8'h09, 8'h05};
    tick("t6_fetch", 4'd1, 8'h00, 1'b0, 1'b0);
    start = 1'b0;
    for (int s = 2; s <= 7; s++) tick("t6_pipe", 4'(s), 8'h00, 1'b0, 1'b0);
    tick("t6_diverged", 4'd1, 8'h05, 1'b0, DIV_EXP);
    instruction_valid = 1'b0; next_pc = {4{8'h07}};
    tick("t6_fetch_stall", 4'd1, 8'h05, 1'b0, DIV_EXP);
    instruction_valid = 1'b1;
    for (int s = 2; s <= 7; s++) tick("t6_sticky", 4'(s), 8'h05, 1'b0, DIV_EXP);
    tick("t6_sticky_pc", 4'd1, 8'h07, 1'b0, DIV_EXP);

    // 7: start with an empty mask goes straight to DONE
    reset = 1'b1;
    tick("t7_reset", 4'd0, 8'h00, 1'b0, 1'b0);
    reset = 1'b0; start = 1'b1; thread_enable = 4'b0000;
    tick("t7_empty_mask", 4'd8, 8'h00, 1'b1, 1'b0);
    start = 1'b0;
    tick("t7_done_hold", 4'd8, 8'h00, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
